mem_arbiter: RTL
================

# mem_arbiter

Shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. It latches one request at a time and holds the memory signals for a fixed access latency. It returns read data with a one-cycle ready pulse and raises per-stage stall signals that the hazard unit ORs into its freeze/flush logic. Data accesses take priority over fetch, so a stalled MEM stage always makes progress.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width
- LATENCY, 2, memory access cycles, ≥1; mem_rdata valid in the LATENCY-th cycle of mem_en high
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- if_req_f  in  1  fetch read request; held until if_ready_f
- if_adr_f  in  ADDR_W  fetch address
- if_rdata_f  out  DATA_W  fetched word; valid while if_ready_f
- if_ready_f  out  1  one-cycle completion pulse for fetch
- dm_req_m  in  1  data request; held until dm_ready_m
- dm_we_m  in  1  1 = store, 0 = load
- dm_adr_m  in  ADDR_W  data address
- dm_wdata_m  in  DATA_W  store data
- dm_rdata_m  out  DATA_W  load data; valid while dm_ready_m
- dm_ready_m  out  1  one-cycle completion pulse for data
- mem_en, mem_we  out  1 each  memory enable and write enable
- mem_adr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_f  out  1  = if_req_f && !if_ready_f
- stall_m  out  1  = dm_req_m && !dm_ready_m

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE with dm_req_m high: latch dm_adr_m, dm_we_m and dm_wdata_m; go to BUSY_D; set cnt = LATENCY-1.
- IDLE with only if_req_f high: latch if_adr_f with we = 0; go to BUSY_I; set cnt = LATENCY-1.
- IDLE with both requests high: data wins. Fetch waits; stall_f stays high.
- BUSY_x: mem_en = 1. mem_we, mem_adr and mem_wdata come from the latched registers. Request-input changes are ignored.
- BUSY_x with cnt ≠ 0: decrement cnt.
- BUSY_x with cnt = 0: if the access is a read, capture mem_rdata into the rdata register of the granted side. Go to DONE and remember the grant.
- DONE: mem_en = 0. The granted side's ready is 1 for exactly this cycle. The next state is always IDLE, so a held request cannot be re-granted.
- A store leaves dm_rdata_m unchanged. Its dm_ready_m pulse marks write completion.
- A request dropped mid-transfer (e.g. fetch squashed by flush_d) does not abort the transfer. The access completes and ready still pulses; the requester ignores it.
- Reset (any cycle, including mid-transfer): state = IDLE, cnt = 0, grant = none. All mem_* outputs = 0, both rdata registers = 0, both ready = 0. The in-flight access is abandoned.
- stall_f and stall_m are combinational from the request inputs and the registered ready signals.

## Timing
- Request seen in IDLE at cycle 0 → mem_en high in cycles 1..LATENCY → ready high in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Each access occupies LATENCY+2 cycles.
- A request deferred behind a data access is granted in the IDLE cycle after that access's DONE.
- mem_* outputs and ready/rdata are registered. Only the stall_f and stall_m outputs are combinational.
- cnt width is clog2(LATENCY), minimum 1 bit.

## Structure
- Shared package mem_pkg: state encoding localparams (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, DONE = 2'd3), grant id constants (GNT_NONE, GNT_I, GNT_D), and the default ADDR_W/DATA_W.
- Single module; no sub-module needed. The latency counter stays inline.

## Test plan
- Lone fetch, LATENCY = 2, if_adr_f = 8'h10, memory returns 16'hBEEF → mem_en high cycles 1–2 with mem_adr = 8'h10 and mem_we = 0; if_ready_f = 1 and if_rdata_f = 16'hBEEF in cycle 3; stall_f high in cycles 0–2.
- Simultaneous fetch (8'h04) and load (8'h20) at cycle 0 → data is served first with dm_ready_m in cycle 3. The fetch is granted in cycle 4, with mem_adr = 8'h04 in cycles 5–6 and if_ready_f in cycle 7.
- Store dm_adr_m = 8'h30, dm_wdata_m = 16'h1234 → mem_we = 1 and mem_wdata = 16'h1234 in cycles 1–2; dm_ready_m in cycle 3; dm_rdata_m unchanged from its prior value.
- Fetch squashed: if_req_f drops in cycle 1 → the access still completes; if_ready_f pulses in cycle 3; a new if_req_f raised in cycle 3 is granted in cycle 4, not cycle 3.
- Reset asserted in cycle 1 of a load → on the same edge, mem_en = 0, dm_ready_m never pulses, and the state is IDLE. The held dm_req_m is re-granted in the first cycle after reset deasserts.
- LATENCY = 1 build → mem_en is high for a single cycle and ready arrives in cycle 2. Back-to-back loads complete every 3 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------+
// | mem_pkg                                                              |
// | Shared state encoding, grant ids and default widths for mem_arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_I    = 2'd1;
    localparam gnt_t GNT_D    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Shares a single-port memory between fetch and data; data has priority|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_f,
    input  logic [ADDR_W-1:0] if_adr_f,
    output logic [DATA_W-1:0] if_rdata_f,
    output logic              if_ready_f,
    input  logic              dm_req_m,
    input  logic              dm_we_m,
    input  logic [ADDR_W-1:0] dm_adr_m,
    input  logic [DATA_W-1:0] dm_wdata_m,
    output logic [DATA_W-1:0] dm_rdata_m,
    output logic              dm_ready_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    localparam int               CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

    state_t              r_state,     w_state;
    logic [CNT_W-1:0]    r_cnt,       w_cnt;
    gnt_t                r_gnt,       w_gnt;
    logic                r_mem_en,    w_mem_en;
    logic                r_mem_we,    w_mem_we;
    logic [ADDR_W-1:0]   r_mem_adr,   w_mem_adr;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata,  w_dm_rdata;
    logic                r_if_ready,  w_if_ready;
    logic                r_dm_ready,  w_dm_ready;

    // The mem_* registers double as the latched request for the whole access.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_gnt       = r_gnt;
        w_mem_en    = r_mem_en;
        w_mem_we    = r_mem_we;
        w_mem_adr   = r_mem_adr;
        w_mem_wdata = r_mem_wdata;
        w_if_rdata  = r_if_rdata;
        w_dm_rdata  = r_dm_rdata;
        w_if_ready  = 1'b0;
        w_dm_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req_m) begin
                    w_state     = BUSY_D;
                    w_cnt       = c_cnt_load;
                    w_mem_en    = 1'b1;
                    w_mem_we    = dm_we_m;
                    w_mem_adr   = dm_adr_m;
                    w_mem_wdata = dm_wdata_m;
                end else if (if_req_f) begin
                    w_state     = BUSY_I;
                    w_cnt       = c_cnt_load;
                    w_mem_en    = 1'b1;
                    w_mem_we    = 1'b0;
                    w_mem_adr   = if_adr_f;
                    w_mem_wdata = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_state     = DONE;
                    w_mem_en    = 1'b0;
                    w_mem_we    = 1'b0;
                    w_mem_adr   = '0;
                    w_mem_wdata = '0;
                    if (r_state == BUSY_I) begin
                        w_gnt      = GNT_I;
                        w_if_ready = 1'b1;
                        w_if_rdata = mem_rdata;
                    end else begin
                        w_gnt      = GNT_D;
                        w_dm_ready = 1'b1;
                        if (!r_mem_we) begin
                            w_dm_rdata = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                // Always pass through IDLE so a still-held request is not re-granted.
                w_state = IDLE;
                w_gnt   = GNT_NONE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gnt       <= GNT_NONE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_gnt       <= w_gnt;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_adr   <= w_mem_adr;
            r_mem_wdata <= w_mem_wdata;
            r_if_rdata  <= w_if_rdata;
            r_dm_rdata  <= w_dm_rdata;
            r_if_ready  <= w_if_ready;
            r_dm_ready  <= w_dm_ready;
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_adr    = r_mem_adr;
    assign mem_wdata  = r_mem_wdata;
    assign if_rdata_f = r_if_rdata;
    assign dm_rdata_m = r_dm_rdata;
    assign if_ready_f = r_if_ready;
    assign dm_ready_m = r_dm_ready;

    assign stall_f = if_req_f && !r_if_ready;
    assign stall_m = dm_req_m && !r_dm_ready;

endmodule

`default_nettype wire
